// File: rtl/alu_arbiter_if.sv
// Bus bundle between two datapath requesters, the response consumer and the
// shared-ALU arbiter. The master side drives requests and takes responses;
// the slave side is the arbiter itself.
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [1:0]   req0_control;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [1:0]   req1_control;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [N-1:0] resp_result;
    logic [3:0]   resp_flags;

    modport master (
        output req0_valid, req0_a, req0_b, req0_control,
        output req1_valid, req1_a, req1_b, req1_control,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_flags
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_control,
        input  req1_valid, req1_a, req1_b, req1_control,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shared ALU with a two-port round-robin arbiter in front and a single
// registered response slot behind it. One operation per cycle is sustained
// because a consumed slot can be refilled on the same clock edge.

// Combinational ALU: 00=add 01=sub 10=and 11=or, flags are {v,c,n,z}.
// Subtraction is a + ~b + 1, so c=1 means "no borrow" (a >= b unsigned).
module alu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   control,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);
    logic [N:0] sum;
    logic       v;
    logic       c;

    // Compute result, carry and signed overflow for the selected operation
    always_comb begin
        sum    = '0;
        v      = 1'b0;
        c      = 1'b0;
        result = '0;
        case (control)
            2'b00: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[N-1:0];
                c      = sum[N];
                v      = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            2'b01: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                result = sum[N-1:0];
                c      = sum[N];
                v      = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
            2'b10: begin
                result = a & b;
            end
            default: begin
                result = a | b;
            end
        endcase
        flags = {v, c, result[N-1], (result == '0)};
    end
endmodule

module alu_arbiter #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] op_count
);
    logic         resp_valid;
    logic         resp_id;
    logic [N-1:0] resp_result;
    logic [3:0]   resp_flags;
    logic         rr_ptr;

    logic         slot_free;
    logic         grant_valid;
    logic         grant_id;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_control;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    // The slot can take a new op if it is empty or being drained this cycle
    assign slot_free = !resp_valid || bus.resp_ready;

    // Round-robin grant; a lone requester wins regardless of the pointer
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = rr_ptr;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid &&  grant_id;

    assign alu_a       = grant_id ? bus.req1_a       : bus.req0_a;
    assign alu_b       = grant_id ? bus.req1_b       : bus.req0_b;
    assign alu_control = grant_id ? bus.req1_control : bus.req0_control;

    alu #(.N(N)) u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .control (alu_control),
        .result  (alu_result),
        .flags   (alu_flags)
    );

    // Load the response slot on acceptance, clear valid on a bare consume
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            rr_ptr      <= 1'b0;
            op_count    <= '0;
        end else if (grant_valid) begin
            resp_valid  <= 1'b1;
            resp_id     <= grant_id;
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
            rr_ptr      <= ~grant_id;
            op_count    <= op_count + CNT_W'(1);
        end else if (bus.resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

    assign bus.resp_valid  = resp_valid;
    assign bus.resp_id     = resp_id;
    assign bus.resp_result = resp_result;
    assign bus.resp_flags  = resp_flags;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed table of ALU vectors, hand-written
// arbitration/backpressure/reset/wrap sequences, then random traffic checked
// against a behavioural model of the arbiter and ALU.
module tb_alu_arbiter;
    localparam int N     = 32;
    localparam int CNT_W = 4;
    localparam longint SMAX = (longint'(1) <<< (N - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (N - 1));

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [CNT_W-1:0] op_count;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .op_count (op_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic         m_valid;
    logic         m_id;
    logic [N-1:0] m_result;
    logic [3:0]   m_flags;
    int           m_prio;
    int           m_count;

    // Ready values sampled inside the last applied cycle
    logic act_r0;
    logic act_r1;

    typedef struct {
        logic         rid;
        logic [1:0]   ctl;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_result;
        logic [3:0]   exp_flags;
    } vec_t;

    vec_t vec_tab [10];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU reference from arithmetic on wide integers
    function automatic void ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [1:0] ctl,
                                    output logic [N-1:0] res, output logic [3:0] flg);
        longint          sa;
        longint          sb;
        longint          sres;
        longint unsigned full;
        logic            v;
        logic            c;
        sa   = $signed(a);
        sb   = $signed(b);
        sres = 0;
        full = 0;
        v    = 1'b0;
        c    = 1'b0;
        case (ctl)
            2'd0: begin
                full = longint'(a) + longint'(b);
                res  = full[N-1:0];
                c    = full[N];
                sres = sa + sb;
                v    = (sres > SMAX) || (sres < SMIN);
            end
            2'd1: begin
                res  = a - b;
                c    = (a >= b);
                sres = sa - sb;
                v    = (sres > SMAX) || (sres < SMIN);
            end
            2'd2: res = a & b;
            default: res = a | b;
        endcase
        flg = {v, c, res[N-1], (res == '0)};
    endfunction

    // Drive one cycle, check readys and response against the model, advance
    task automatic apply_stimulus(input logic v0, input logic [1:0] c0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                                  input logic v1, input logic [1:0] c1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                                  input logic rr);
        int           g;
        logic [N-1:0] nres;
        logic [3:0]   nflg;
        bus.req0_valid   = v0;
        bus.req0_control = c0;
        bus.req0_a       = a0;
        bus.req0_b       = b0;
        bus.req1_valid   = v1;
        bus.req1_control = c1;
        bus.req1_a       = a1;
        bus.req1_b       = b1;
        bus.resp_ready   = rr;
        #1;
        g = -1;
        if (!m_valid || rr) begin
            if (v0 && v1) g = m_prio;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        act_r0 = bus.req0_ready;
        act_r1 = bus.req1_ready;
        check_output("req0_ready", act_r0, (g == 0));
        check_output("req1_ready", act_r1, (g == 1));
        check_output("resp_valid", bus.resp_valid, m_valid);
        check_output("resp_id", bus.resp_id, m_id);
        check_output("resp_result", bus.resp_result, m_result);
        check_output("resp_flags", bus.resp_flags, m_flags);
        check_output("op_count", op_count, m_count);
        if (g == 0) ref_alu(a0, b0, c0, nres, nflg);
        else        ref_alu(a1, b1, c1, nres, nflg);
        @(posedge clk);
        if (g >= 0) begin
            m_valid  = 1'b1;
            m_id     = (g == 1);
            m_result = nres;
            m_flags  = nflg;
            m_prio   = 1 - g;
            m_count  = (m_count + 1) % (1 << CNT_W);
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Synchronous reset pulse, then compare every output to zero
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(posedge clk);
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_result = '0;
        m_flags  = '0;
        m_prio   = 0;
        m_count  = 0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_output({tag, "_valid"}, bus.resp_valid, 1'b0);
        check_output({tag, "_id"}, bus.resp_id, 1'b0);
        check_output({tag, "_result"}, bus.resp_result, '0);
        check_output({tag, "_flags"}, bus.resp_flags, 4'h0);
        check_output({tag, "_count"}, op_count, '0);
    endtask

    function automatic logic [N-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(N-1){1'b0}}};
            3: return {1'b0, {(N-1){1'b1}}};
            default: return N'($urandom);
        endcase
    endfunction

    // Main test sequence
    initial begin
        logic [N-1:0] held;

        vec_tab[0] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001};
        vec_tab[1] = '{1'b0, 2'd0, 32'h7BF0_5BC3, 32'h2472_9415, 32'hA062_EFD8, 4'b1010};
        vec_tab[2] = '{1'b0, 2'd1, 32'hFE13_6D0D, 32'h642C_A4BE, 32'h99E6_C84F, 4'b0110};
        vec_tab[3] = '{1'b1, 2'd2, 32'h0733_64E6, 32'hC123_C640, 32'h0123_4440, 4'b0000};
        vec_tab[4] = '{1'b1, 2'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000};
        vec_tab[5] = '{1'b0, 2'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0101};
        vec_tab[6] = '{1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010};
        vec_tab[7] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101};
        vec_tab[8] = '{1'b1, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101};
        vec_tab[9] = '{1'b0, 2'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100};

        bus.req0_valid = 1'b0; bus.req0_control = 2'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_control = 2'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b0;

        do_reset("reset");

        // Single-requester table vectors with constant expected responses
        for (int i = 0; i < 10; i++) begin
            if (!vec_tab[i].rid)
                apply_stimulus(1'b1, vec_tab[i].ctl, vec_tab[i].a, vec_tab[i].b, 1'b0, 2'd0, '0, '0, 1'b1);
            else
                apply_stimulus(1'b0, 2'd0, '0, '0, 1'b1, vec_tab[i].ctl, vec_tab[i].a, vec_tab[i].b, 1'b1);
            #1;
            check_output($sformatf("tab%0d_valid", i), bus.resp_valid, 1'b1);
            check_output($sformatf("tab%0d_id", i), bus.resp_id, vec_tab[i].rid);
            check_output($sformatf("tab%0d_result", i), bus.resp_result, vec_tab[i].exp_result);
            check_output($sformatf("tab%0d_flags", i), bus.resp_flags, vec_tab[i].exp_flags);
        end

        // Both requesters valid every cycle: grants alternate 0,1,0,1
        do_reset("rst_alt");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 2'd1, 32'hFE13_6D0D, 32'h642C_A4BE,
                           1'b1, 2'd2, 32'h0733_64E6, 32'hC123_C640, 1'b1);
            check_output($sformatf("alt%0d_r0", i), act_r0, (i % 2 == 0));
            check_output($sformatf("alt%0d_r1", i), act_r1, (i % 2 == 1));
            check_output($sformatf("alt%0d_result", i), bus.resp_result,
                         (i % 2 == 0) ? 32'h99E6_C84F : 32'h0123_4440);
            check_output($sformatf("alt%0d_flags", i), bus.resp_flags,
                         (i % 2 == 0) ? 4'b0110 : 4'b0000);
        end

        // Backpressure: three stalled cycles hold the slot and block both ports
        held = bus.resp_result;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 2'd1, 32'hFE13_6D0D, 32'h642C_A4BE,
                           1'b1, 2'd2, 32'h0733_64E6, 32'hC123_C640, 1'b0);
            check_output($sformatf("bp%0d_r0", i), act_r0, 1'b0);
            check_output($sformatf("bp%0d_r1", i), act_r1, 1'b0);
            check_output($sformatf("bp%0d_hold", i), bus.resp_result, held);
        end
        apply_stimulus(1'b1, 2'd1, 32'hFE13_6D0D, 32'h642C_A4BE,
                       1'b1, 2'd2, 32'h0733_64E6, 32'hC123_C640, 1'b1);
        check_output("bp_release_r0", act_r0, 1'b1);
        check_output("bp_reload_result", bus.resp_result, 32'h99E6_C84F);

        // Reset while a response is stalled drops it and restores req0 priority
        apply_stimulus(1'b1, 2'd1, 32'hFE13_6D0D, 32'h642C_A4BE,
                       1'b1, 2'd2, 32'h0733_64E6, 32'hC123_C640, 1'b0);
        do_reset("rst_mid");
        apply_stimulus(1'b1, 2'd0, 32'h1, 32'h2, 1'b1, 2'd0, 32'h3, 32'h4, 1'b1);
        check_output("post_rst_r0", act_r0, 1'b1);
        check_output("post_rst_r1", act_r1, 1'b0);

        // Counter wrap: 17 accepted ops on a 4-bit counter read back 1
        do_reset("rst_wrap");
        for (int i = 0; i < 17; i++)
            apply_stimulus(1'b1, 2'd0, N'(i), 32'h1, 1'b0, 2'd0, '0, '0, 1'b1);
        check_output("wrap_count", op_count, 4'd1);

        // Random traffic against the model
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                           ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
